// File: rtl/mips_avalon_pkg.sv
// mips_avalon_pkg
// Shared types and defaults for the MIPS Avalon-MM slave memory.
//   resp_e    : Avalon response codes driven on the response port
//   rd_sel_e  : which source currently feeds readdata
//   DEF_*     : default region bases/sizes and wait-state count
//   in_region : byte-address range test against [base, base + 4*words)
package mips_avalon_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_PROG = 2'd1,
        SEL_DATA = 2'd2
    } rd_sel_e;

    localparam int unsigned DEF_WAIT_CYCLES = 2;
    localparam logic [31:0] DEF_PROG_BASE   = 32'hBFC0_0000;
    localparam int unsigned DEF_PROG_WORDS  = 1024;
    localparam logic [31:0] DEF_DATA_BASE   = 32'h0000_1000;
    localparam int unsigned DEF_DATA_WORDS  = 1024;

    // 33-bit compare so a region ending exactly at 4 GiB does not wrap.
    function automatic logic in_region(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input int unsigned words);
        logic [32:0] lo;
        logic [32:0] hi;
        lo = {1'b0, base};
        hi = lo + (33'(words) * 33'd4);
        return ({1'b0, addr} >= lo) && ({1'b0, addr} < hi);
    endfunction

endpackage

// File: rtl/mips_avalon_ram.sv
// mips_avalon_ram
// Single-port word RAM built from four independent byte-lane arrays so each
// lane maps onto block RAM with a plain write enable.
//   clk     : clock
//   i_we    : write strobe (qualified per lane by i_be)
//   i_re    : read strobe; loads o_rdata from the addressed word
//   i_be    : byte-lane enables for writes
//   i_addr  : word index
//   i_wdata : write data
//   o_rdata : registered read data, held between read strobes
module mips_avalon_ram #(
    parameter int unsigned WORDS = 1024,
    parameter int unsigned AW    = 10
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic          i_re,
    input  logic [3:0]    i_be,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] r_mem [WORDS];
            logic [7:0] r_q;

            // Contents power up as zero from the device configuration and
            // are deliberately never reset.
            always_ff @(posedge clk) begin
                if (i_we && i_be[gi]) begin
                    r_mem[i_addr] <= i_wdata[8*gi +: 8];
                end
                if (i_re) begin
                    r_q <= r_mem[i_addr];
                end
            end

            assign o_rdata[8*gi +: 8] = r_q;
        end
    endgenerate

endmodule

// File: rtl/mips_avalon_mem.sv
// mips_avalon_mem
// Avalon-MM slave memory with a program region and a data region, a fixed
// number of wait states per transfer and Avalon response codes.
//   clk, rst_n  : clock, asynchronous active-low reset
//   address     : word-aligned byte address
//   byteenable  : write lane enables (reads always return the full word)
//   read, write : commands, held until waitrequest is seen low
//   writedata   : write data
//   waitrequest : combinational stall
//   readdata    : data of the most recent completed read (0 after an error)
//   response    : 00 OKAY, 10 SLAVEERROR, 11 DECODEERROR (completion cycle only)
module mips_avalon_mem
    import mips_avalon_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter logic [31:0] PROG_BASE   = DEF_PROG_BASE,
    parameter int unsigned PROG_WORDS  = DEF_PROG_WORDS,
    parameter logic [31:0] DATA_BASE   = DEF_DATA_BASE,
    parameter int unsigned DATA_WORDS  = DEF_DATA_WORDS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] address,
    input  logic [3:0]  byteenable,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic        waitrequest,
    output logic [31:0] readdata,
    output logic [1:0]  response
);

    localparam logic [3:0]  WAIT_N = 4'(WAIT_CYCLES);
    localparam int unsigned PAW    = (PROG_WORDS > 1) ? $clog2(PROG_WORDS) : 1;
    localparam int unsigned DAW    = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1;

    logic [3:0]     r_cnt;
    logic [3:0]     w_cnt_next;
    resp_e          r_resp;
    resp_e          w_resp_next;
    resp_e          w_resp_dec;
    rd_sel_e        r_sel;
    rd_sel_e        w_sel_next;

    logic           w_req;
    logic           w_capture;
    logic           w_done;
    logic           w_ok;
    logic           w_prog_hit;
    logic           w_data_hit;
    logic [PAW-1:0] w_prog_idx;
    logic [DAW-1:0] w_data_idx;
    logic [31:0]    w_prog_q;
    logic [31:0]    w_data_q;

    assign w_req      = read | write;
    // Capture edge: the edge on which cnt reaches WAIT_CYCLES.
    assign w_capture  = w_req && (r_cnt == WAIT_N - 4'd1);
    // Completion cycle: cnt has reached WAIT_CYCLES, waitrequest is low.
    assign w_done     = w_req && (r_cnt == WAIT_N);
    // Gated by rst_n so the stall drops the moment reset is applied.
    assign waitrequest = rst_n && w_req && (r_cnt < WAIT_N);

    // Program region wins if a misconfiguration makes the regions overlap.
    assign w_prog_hit = in_region(address, PROG_BASE, PROG_WORDS);
    assign w_data_hit = !w_prog_hit && in_region(address, DATA_BASE, DATA_WORDS);
    assign w_prog_idx = PAW'((address - PROG_BASE) >> 2);
    assign w_data_idx = DAW'((address - DATA_BASE) >> 2);

    always_comb begin
        w_resp_dec = RESP_OKAY;
        if (read && write) begin
            w_resp_dec = RESP_SLVERR;
        end else if (!w_prog_hit && !w_data_hit) begin
            w_resp_dec = RESP_DECERR;
        end else if (address[1:0] != 2'b00) begin
            w_resp_dec = RESP_SLVERR;
        end
    end

    assign w_ok = (w_resp_dec == RESP_OKAY);

    mips_avalon_ram #(.WORDS(PROG_WORDS), .AW(PAW)) u_prog_ram (
        .clk     (clk),
        .i_we    (w_done && write && w_ok && w_prog_hit),
        .i_re    (w_capture && read && w_ok && w_prog_hit),
        .i_be    (byteenable),
        .i_addr  (w_prog_idx),
        .i_wdata (writedata),
        .o_rdata (w_prog_q)
    );

    mips_avalon_ram #(.WORDS(DATA_WORDS), .AW(DAW)) u_data_ram (
        .clk     (clk),
        .i_we    (w_done && write && w_ok && w_data_hit),
        .i_re    (w_capture && read && w_ok && w_data_hit),
        .i_be    (byteenable),
        .i_addr  (w_data_idx),
        .i_wdata (writedata),
        .o_rdata (w_data_q)
    );

    always_comb begin
        w_cnt_next  = r_cnt;
        w_resp_next = RESP_OKAY;
        w_sel_next  = r_sel;

        if (!w_req || w_done) begin
            w_cnt_next = 4'd0;
        end else begin
            w_cnt_next = r_cnt + 4'd1;
        end

        // Response is non-OKAY only during the completion cycle.
        if (w_capture) begin
            w_resp_next = w_resp_dec;
        end

        // readdata follows reads only; writes leave it untouched.
        if (w_capture && read) begin
            if (!w_ok) begin
                w_sel_next = SEL_NONE;
            end else if (w_prog_hit) begin
                w_sel_next = SEL_PROG;
            end else begin
                w_sel_next = SEL_DATA;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= 4'd0;
            r_resp <= RESP_OKAY;
            r_sel  <= SEL_NONE;
        end else begin
            r_cnt  <= w_cnt_next;
            r_resp <= w_resp_next;
            r_sel  <= w_sel_next;
        end
    end

    // RAM outputs only change on a read strobe, so selecting them here keeps
    // readdata stable until the next read completes.
    always_comb begin
        readdata = 32'h0;
        case (r_sel)
            SEL_PROG: readdata = w_prog_q;
            SEL_DATA: readdata = w_data_q;
            default:  readdata = 32'h0;
        endcase
    end

    assign response = r_resp;

endmodule

// File: tb/tb_mips_avalon_mem.sv
module tb_mips_avalon_mem;

    localparam int WAIT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] address = 32'h0;
    logic [3:0]  byteenable = 4'h0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = 32'h0;
    logic        waitrequest;
    logic [31:0] readdata;
    logic [1:0]  response;

    always #5 clk = ~clk;

    mips_avalon_mem dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .address     (address),
        .byteenable  (byteenable),
        .read        (read),
        .write       (write),
        .writedata   (writedata),
        .waitrequest (waitrequest),
        .readdata    (readdata),
        .response    (response)
    );

    typedef struct {
        string       name;
        bit          is_read;
        logic [31:0] rdata;
        logic [1:0]  resp;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail = 0;
    int   wait_seen = 0;

    function automatic void check32(input string name, input logic [31:0] act,
                                    input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Monitor: counts stall cycles and scores each completion cycle.
    always @(negedge clk) begin
        if (!rst_n || !(read || write)) begin
            wait_seen = 0;
        end else if (waitrequest) begin
            wait_seen++;
        end else begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_completion: got addr %h expected none", address);
            end else begin
                mon_e = sb.pop_front();
                check32({mon_e.name, " resp"}, 32'(response), 32'(mon_e.resp));
                check32({mon_e.name, " waits"}, 32'(wait_seen), 32'(WAIT));
                if (mon_e.is_read) begin
                    check32({mon_e.name, " rdata"}, readdata, mon_e.rdata);
                end
                $display("xfer %-18s addr=%h rd=%0b wr=%0b resp=%b rdata=%h waits=%0d",
                         mon_e.name, address, read, write, response, readdata, wait_seen);
            end
            wait_seen = 0;
        end
    end

    task automatic wait_done(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (!waitrequest) done = 1'b1;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: got waitrequest stuck high expected completion", name);
            sb.delete();
        end
    endtask

    task automatic do_xfer(input string name, input logic [31:0] a, input logic [3:0] be,
                           input bit rd, input bit wr, input logic [31:0] wd,
                           input logic [1:0] exp_resp, input logic [31:0] exp_rd);
        exp_t e;
        e.name = name; e.is_read = rd; e.rdata = exp_rd; e.resp = exp_resp;
        sb.push_back(e);
        @(posedge clk); #1;
        address = a; byteenable = be; writedata = wd; read = rd; write = wr;
        wait_done(name);
        @(posedge clk); #1;
        read = 1'b0; write = 1'b0;
    endtask

    task automatic wr(input string name, input logic [31:0] a, input logic [3:0] be,
                      input logic [31:0] d, input logic [1:0] resp);
        do_xfer(name, a, be, 1'b0, 1'b1, d, resp, 32'h0);
    endtask

    task automatic rd(input string name, input logic [31:0] a,
                      input logic [31:0] d, input logic [1:0] resp);
        do_xfer(name, a, 4'hF, 1'b1, 1'b0, 32'h0, resp, d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        #12;
        check32("reset waitrequest", 32'(waitrequest), 32'h0);
        check32("reset response", 32'(response), 32'h0);
        check32("reset readdata", readdata, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check32("idle waitrequest", 32'(waitrequest), 32'h0);

        // Loader-style program write and readback, plus region edges.
        wr("prog_wr", 32'hBFC0_0000, 4'hF, 32'hDEADBEEF, 2'b00);
        rd("prog_rd", 32'hBFC0_0000, 32'hDEADBEEF, 2'b00);
        wr("prog_last_wr", 32'hBFC0_0FFC, 4'hF, 32'h600DC0DE, 2'b00);
        rd("prog_last_rd", 32'hBFC0_0FFC, 32'h600DC0DE, 2'b00);
        wr("prog_end_wr", 32'hBFC0_1000, 4'hF, 32'h12345678, 2'b11);
        rd("prog_end_rd", 32'hBFC0_1000, 32'h0, 2'b11);

        // Byte-lane merge and empty byteenable.
        wr("data_wr", 32'h0000_1000, 4'hF, 32'h11223344, 2'b00);
        wr("data_be0101", 32'h0000_1000, 4'b0101, 32'hAABBCCDD, 2'b00);
        rd("data_merge_rd", 32'h0000_1000, 32'h11BB33DD, 2'b00);
        wr("data_be0000", 32'h0000_1000, 4'b0000, 32'hFFFFFFFF, 2'b00);
        rd("data_be0_rd", 32'h0000_1000, 32'h11BB33DD, 2'b00);

        // Unmapped read: error only in completion cycle, readdata cleared.
        rd("unmapped_rd", 32'h0000_0000, 32'h0, 2'b11);
        check32("decerr resp cleared", 32'(response), 32'h0);
        check32("decerr readdata held", readdata, 32'h0);
        wr("data_last_wr", 32'h0000_1FFC, 4'hF, 32'hA5A5A5A5, 2'b00);
        rd("data_last_rd", 32'h0000_1FFC, 32'hA5A5A5A5, 2'b00);
        rd("data_end_rd", 32'h0000_2000, 32'h0, 2'b11);

        // Slave errors leave memory untouched.
        rd("misaligned_rd", 32'h0000_1002, 32'h0, 2'b10);
        wr("w1004", 32'h0000_1004, 4'hF, 32'h0BADF00D, 2'b00);
        do_xfer("rdwr_both", 32'h0000_1004, 4'hF, 1'b1, 1'b1, 32'h12345678, 2'b10, 32'h0);
        wr("misaligned_wr", 32'h0000_1006, 4'hF, 32'h00000000, 2'b10);
        rd("r1004", 32'h0000_1004, 32'h0BADF00D, 2'b00);

        // Aborted write after one wait cycle, then a fresh full write.
        wr("w1008_zero", 32'h0000_1008, 4'hF, 32'h0, 2'b00);
        @(posedge clk); #1;
        address = 32'h0000_1008; byteenable = 4'hF; writedata = 32'hFFFFFFFF; write = 1'b1;
        @(posedge clk); #1;
        check32("abort still waiting", 32'(waitrequest), 32'h1);
        write = 1'b0;
        check32("abort response", 32'(response), 32'h0);
        rd("abort_rd", 32'h0000_1008, 32'h0, 2'b00);
        wr("w1008_full", 32'h0000_1008, 4'hF, 32'h55AA55AA, 2'b00);
        rd("r1008", 32'h0000_1008, 32'h55AA55AA, 2'b00);

        // Reset in the middle of a read; the held read restarts afterwards.
        wr("w1010", 32'h0000_1010, 4'hF, 32'h13579BDF, 2'b00);
        rd("r1010", 32'h0000_1010, 32'h13579BDF, 2'b00);
        e.name = "rst_mid_rd"; e.is_read = 1'b1; e.rdata = 32'h13579BDF; e.resp = 2'b00;
        sb.push_back(e);
        @(posedge clk); #1;
        address = 32'h0000_1010; byteenable = 4'hF; read = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check32("rst waitrequest", 32'(waitrequest), 32'h0);
        check32("rst response", 32'(response), 32'h0);
        check32("rst readdata", readdata, 32'h0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        wait_done("rst_mid_rd");
        @(posedge clk); #1;
        read = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check32("scoreboard drained", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_avalon_mem.md
# mips_avalon_mem

Avalon-MM slave memory for the bus-based MIPS CPU: one 32-bit port with byte enables, programmable wait states, and an Avalon response code. It backs both the reset-vector program region and a data region. The CPU and the program loader share it as bus masters through an external mux.

## Interface
- `WAIT_CYCLES`, default 2: waitrequest cycles per transfer, range 1..15.
- `PROG_BASE`, default 32'hBFC0_0000: byte base of the program region.
- `PROG_WORDS`, default 1024: program region size in words.
- `DATA_BASE`, default 32'h0000_1000: byte base of the data region.
- `DATA_WORDS`, default 1024: data region size in words.
- `clk  in  1`: single clock; all state changes on rising edge.
- `rst_n  in  1`: reset, asynchronous and active-low. Integrators tie it high if unused.
- `address  in  32`: byte address; must be word aligned.
- `byteenable  in  4`: lane i selects bits 8i+7:8i.
- `read  in  1`: read request.
- `write  in  1`: write request.
- `writedata  in  32`: write data.
- `waitrequest  out  1`: slave stall.
- `readdata  out  32`: read data.
- `response  out  2`: 00 OKAY, 10 SLAVEERROR, 11 DECODEERROR; 01 is never driven.

## Operation
- A request is `read | write`. The master holds address, byteenable, writedata and the command stable until it samples waitrequest low at a rising edge.
- Address decode:
  - The program region is [PROG_BASE, PROG_BASE+4*PROG_WORDS).
  - The data region is [DATA_BASE, DATA_BASE+4*DATA_WORDS).
  - Any other address is a decode error.
- Both regions are readable and writable, so the loader can write program words.
- Write: only enabled lanes are updated; other bytes are preserved. Byteenable 0000 completes OKAY with no change.
- Read: returns the full word regardless of byteenable. The master extracts bytes.
- Error cases:
  - Unmapped address: response 11. No write is performed. readdata is 32'h0.
  - Misaligned address (address[1:0] != 0): response 10. No write is performed. readdata is 32'h0.
  - read and write asserted together: response 10. No write is performed. readdata is 32'h0.
- Memory contents are not cleared by reset and initialise to zero at time 0.

## Timing
- A wait counter `cnt` (4 bits) increments on every edge where a request is present and `cnt < WAIT_CYCLES`.
- `waitrequest = request && (cnt < WAIT_CYCLES)`. It is combinational, so it rises in the same cycle the request appears.
- Idle waitrequest is 0.
- On the edge where `cnt` becomes WAIT_CYCLES, readdata and response are registered from the array and decode.
- The completion cycle is the cycle where `cnt == WAIT_CYCLES` and waitrequest is low. On the rising edge that ends it:
  - The write is committed.
  - `cnt` returns to 0.
  - response returns to 00.
- readdata holds its last value until the next read completes.
- Latency: a transfer completes on the (WAIT_CYCLES+1)-th rising edge after the request is first sampled.
- Back-to-back requests restart counting from 0; there is no pipelining.
- If the request drops before completion, `cnt` clears, nothing is written, and response stays 00.
- Reset (async, rst_n=0): `cnt`=0, readdata=0, response=00. waitrequest is 0 while no request is present.
- Reset asserted mid-transfer aborts it with no write. After release, a still-held request restarts its full wait period.

## Structure
- Package `mips_avalon_pkg` holds:
  - The response enum: RESP_OKAY, RESP_SLVERR, RESP_DECERR.
  - Default region base and size constants.
- Natural sub-module `mips_avalon_ram`: a byte-lane-enabled word RAM, instanced once per region, with the address decoder and wait FSM in the top.
- Expected size is about 150-250 lines.

## Test plan
- Loader-style write 32'hDEADBEEF to 0xBFC00000 with be=1111, then read it back:
  - Each transfer shows waitrequest high for 2 cycles and completes on the 3rd edge.
  - readdata = DEADBEEF with response 00.
- Write 32'h11223344 to 0x1000, then write be=0101 data 32'hAABBCCDD, then read: 0x11BB33DD.
- Read 0x00000000 (unmapped): response 11 for exactly the completion cycle; 0x0 is read afterwards.
- Read 0x1002 (misaligned): response 10. Assert read and write together on 0x1004: response 10 and the memory word is unchanged.
- Drop write after 1 wait cycle at 0x1008: the word stays 0. A following full write completes after a fresh 2-cycle wait.
- Pull rst_n low mid-read: waitrequest, response and readdata go to 0 immediately. After release the held read completes WAIT_CYCLES+1 edges later with correct data.
